decoder_in_debounce: RTL and testbench

//  Input conditioning stage directly upstream of the decoder project core.

---
 rtl/decoder_in_debounce_if.sv | 20 ++
 rtl/decoder_in_debounce.sv | 72 +++++++
 tb/tb_decoder_in_debounce.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/decoder_in_debounce_if.sv
// rtl/decoder_in_debounce_if.sv - valid/ready code handshake between debounce stage and decoder
interface decoder_in_debounce_if #(
    parameter int WIDTH = 7
);
    logic [WIDTH-1:0] code_out;
    logic             code_valid;
    logic             code_ready;

    modport master (
        output code_out,
        output code_valid,
        input  code_ready
    );

    modport slave (
        input  code_out,
        input  code_valid,
        output code_ready
    );
endinterface

// File: rtl/decoder_in_debounce.sv
// rtl/decoder_in_debounce.sv - synchronise, debounce and present each new stable input code once
module decoder_in_debounce #(
    parameter int WIDTH         = 7,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       io_in,
    decoder_in_debounce_if.master  code_if,
    output logic                   stable_o,
    output logic [7:0]             change_cnt
);
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    typedef enum logic {EMPTY, PEND} state_t;

    logic [WIDTH-1:0] s1_q, s2_q, cand_q, out_q;
    logic [CNT_W-1:0] cnt_q;
    logic             have_q, stable_q;
    logic [7:0]       chg_q;
    state_t           state_q;

    logic at_max, commit;

    assign at_max = (cnt_q == CNT_MAX) && (s2_q == cand_q);
    // A code equal to the one already presented is never re-presented.
    assign commit = at_max && (!have_q || (cand_q != out_q))
                  && ((state_q == EMPTY) || code_if.code_ready);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_q     <= '0;
            s2_q     <= '0;
            cand_q   <= '0;
            cnt_q    <= '0;
            out_q    <= '0;
            have_q   <= 1'b0;
            stable_q <= 1'b0;
            chg_q    <= '0;
            state_q  <= EMPTY;
        end else begin
            s1_q     <= io_in;
            s2_q     <= s1_q;
            stable_q <= at_max;

            if (s2_q != cand_q) begin
                cand_q <= s2_q;
                cnt_q  <= '0;
            end else if (cnt_q < CNT_MAX) begin
                cnt_q  <= cnt_q + CNT_W'(1);
            end

            if (commit) begin
                out_q  <= cand_q;
                have_q <= 1'b1;
                chg_q  <= chg_q + 8'd1;
            end

            case (state_q)
                EMPTY: if (commit) state_q <= PEND;
                PEND:  if (code_if.code_ready && !commit) state_q <= EMPTY;
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign code_if.code_out   = out_q;
    assign code_if.code_valid = (state_q == PEND);
    assign stable_o           = stable_q;
    assign change_cnt         = chg_q;
endmodule

// File: tb/tb_decoder_in_debounce.sv
// tb/tb_decoder_in_debounce.sv - randomized and directed checks against a behavioural model
module tb_decoder_in_debounce;
    localparam int W = 7;
    localparam int S = 4;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] io_in = '0;
    logic         stable_o;
    logic [7:0]   change_cnt;

    decoder_in_debounce_if #(.WIDTH(W)) dif ();

    decoder_in_debounce #(.WIDTH(W), .STABLE_CYCLES(S)) dut (
        .clock      (clock),
        .reset      (reset),
        .io_in      (io_in),
        .code_if    (dif),
        .stable_o   (stable_o),
        .change_cnt (change_cnt)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the synchroniser is a two-deep delay line, the
    // candidate ages (unsaturated) while the delayed input holds its value.
    int m_sync[2];
    int m_cand, m_age, m_out, m_cnt;
    bit m_have, m_valid, m_stable;

    function automatic void model_reset();
        m_sync[0] = 0; m_sync[1] = 0;
        m_cand = 0; m_age = 0; m_out = 0; m_cnt = 0;
        m_have = 0; m_valid = 0; m_stable = 0;
    endfunction

    always @(posedge clock) begin
        if (!reset) begin
            int  s2v;
            bit  ripe, take;
            s2v    = m_sync[1];
            ripe   = (m_age >= S) && (s2v == m_cand);
            take   = ripe && (!m_have || m_cand != m_out) && (!m_valid || dif.code_ready);
            m_stable = ripe;
            if (take) begin
                m_out   = m_cand;
                m_have  = 1;
                m_cnt   = (m_cnt + 1) % 256;
                m_valid = 1;
            end else if (m_valid && dif.code_ready) begin
                m_valid = 0;
            end
            if (s2v != m_cand) begin
                m_cand = s2v;
                m_age  = 0;
            end else begin
                m_age++;
            end
            m_sync[1] = m_sync[0];
            m_sync[0] = int'(io_in);
        end
    end

    task automatic compare_all();
        check("valid",  32'(dif.code_valid), 32'(m_valid));
        check("out",    32'(dif.code_out),   32'(m_out));
        check("stable", 32'(stable_o),       32'(m_stable));
        check("cnt",    32'(change_cnt),     32'(m_cnt));
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            @(negedge clock);
            compare_all();
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        int waited;
        model_reset();
        dif.code_ready = 1'b1;
        io_in = 7'b1010001;
        @(negedge clock);
        check("rst_valid", 32'(dif.code_valid), 32'd0);
        check("rst_cnt",   32'(change_cnt),     32'd0);
        apply_reset();

        // First code after reset appears after edge 8 for one cycle.
        cyc(7);
        check("t1_pre_valid", 32'(dif.code_valid), 32'd0);
        cyc(1);
        check("t1_valid", 32'(dif.code_valid), 32'd1);
        check("t1_out",   32'(dif.code_out),   32'h51);
        check("t1_cnt",   32'(change_cnt),     32'd1);
        cyc(1);
        check("t1_drop",  32'(dif.code_valid), 32'd0);

        // Short pulse and return to the committed value.
        io_in = 7'b0000011;
        cyc(3);
        io_in = 7'b1010001;
        cyc(12);
        check("t2_out", 32'(dif.code_out), 32'h51);
        check("t2_cnt", 32'(change_cnt),   32'd1);

        // Held pending code, then a back-to-back replacement.
        dif.code_ready = 1'b0;
        io_in = 7'h12;
        cyc(10);
        cyc(20);
        check("t3_hold_valid", 32'(dif.code_valid), 32'd1);
        check("t3_hold_out",   32'(dif.code_out),   32'h12);
        io_in = 7'h34;
        cyc(12);
        check("t4_wait_out", 32'(dif.code_out), 32'h12);
        dif.code_ready = 1'b1;
        cyc(1);
        check("t4_b2b_valid", 32'(dif.code_valid), 32'd1);
        check("t4_b2b_out",   32'(dif.code_out),   32'h34);
        check("t4_b2b_cnt",   32'(change_cnt),     32'd3);
        cyc(1);
        check("t3_release", 32'(dif.code_valid), 32'd0);

        // Async reset in the middle of a pending code.
        dif.code_ready = 1'b0;
        io_in = 7'h40;
        cyc(12);
        check("t5_pend", 32'(dif.code_valid), 32'd1);
        @(posedge clock);
        #2 reset = 1'b1;
        #1 check("t5_async_valid", 32'(dif.code_valid), 32'd0);
        model_reset();
        io_in = '0;
        dif.code_ready = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        waited = 0;
        while (!dif.code_valid && waited < 12) begin
            cyc(1);
            waited++;
        end
        check("t5_zero_commit", 32'(dif.code_valid), 32'd1);
        check("t5_zero_out",    32'(dif.code_out),   32'd0);
        check("t5_zero_cnt",    32'(change_cnt),     32'd1);

        // 256 distinct commits wrap the change counter.
        apply_reset();
        for (int i = 0; i < 256; i++) begin
            io_in = W'(i) ^ 7'h2A;
            cyc(8);
        end
        cyc(8);
        check("t6_wrap", 32'(change_cnt), 32'd0);

        // Random codes, hold lengths and ready pattern.
        for (int i = 0; i < 300; i++) begin
            int hold;
            hold = $urandom_range(1, 10);
            if ($urandom_range(0, 3) != 0) io_in = W'($urandom_range(0, 7));
            for (int j = 0; j < hold; j++) begin
                dif.code_ready = ($urandom_range(0, 2) != 0);
                cyc(1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
